// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_pkg
// Description : Shared constants and types for the write-back stage and
//               general-purpose register file.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_regfile_pkg;

    // Default data width and register index width
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Index of the hardwired-zero register
    localparam int REG_ZERO   = 0;

    // Width of the committed-write counter
    localparam int CNT_W      = 32;

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [CNT_W-1:0]      cnt_t;

endpackage : wb_regfile_pkg
`default_nettype wire

// File: rtl/wb_regfile_wb_mux.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_wb_mux
// Description : Write-back data select. Picks memory load data or the ALU
//               result under memtoreg. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile_wb_mux
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_memtoreg,
    input  logic [DATA_W-1:0] i_read_data,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic [DATA_W-1:0] o_wb_data
);

    // Load data wins when memtoreg is set, otherwise the ALU result
    always_comb begin
        o_wb_data = i_memtoreg ? i_read_data : i_alu_result;
    end

endmodule : wb_regfile_wb_mux
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : MIPS write-back stage and 2R/1W general-purpose register
//               file. Register 0 reads as zero and ignores writes. Counts
//               effective register writes for debug.
//               Optional macro WB_BYPASS_EN: same-cycle write-to-read bypass
//               on both read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              regwrite,
    input  logic              memtoreg,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [ADDR_W-1:0] mem_write_reg,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  commit_count
);

    localparam int              c_nregs    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_reg_zero = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [c_nregs];
    logic [CNT_W-1:0]  r_commit_count;
    logic [DATA_W-1:0] w_wb_data;
    logic              w_wb_valid;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;

    wb_regfile_wb_mux #(
        .DATA_W       (DATA_W)
    ) u_wb_mux (
        .i_memtoreg   (memtoreg),
        .i_read_data  (read_data),
        .i_alu_result (mem_alu_result),
        .o_wb_data    (w_wb_data)
    );

    // A write is effective only when enabled and not aimed at register 0
    always_comb begin
        w_wb_valid = regwrite && (mem_write_reg != c_reg_zero);
    end

    // Register storage; register 0 is never written since w_wb_valid excludes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_nregs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_valid) begin
            r_regs[mem_write_reg] <= w_wb_data;
        end
    end

    // Committed-write counter, wraps silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_commit_count <= '0;
        end else if (w_wb_valid) begin
            r_commit_count <= r_commit_count + 1'b1;
        end
    end

    // Read port A: storage, optional same-cycle bypass, register 0 forced to zero
    always_comb begin
        w_rs_data = r_regs[rs_addr];
`ifdef WB_BYPASS_EN
        if (w_wb_valid && (rs_addr == mem_write_reg)) begin
            w_rs_data = w_wb_data;
        end
`endif
        if (rs_addr == c_reg_zero) begin
            w_rs_data = '0;
        end
    end

    // Read port B: resolved independently of port A
    always_comb begin
        w_rt_data = r_regs[rt_addr];
`ifdef WB_BYPASS_EN
        if (w_wb_valid && (rt_addr == mem_write_reg)) begin
            w_rt_data = w_wb_data;
        end
`endif
        if (rt_addr == c_reg_zero) begin
            w_rt_data = '0;
        end
    end

    assign rs_data      = w_rs_data;
    assign rt_data      = w_rt_data;
    assign wb_data      = w_wb_data;
    assign wb_valid     = w_wb_valid;
    assign commit_count = r_commit_count;

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Self-checking bench for wb_regfile. A driver applies one
//               input vector per cycle and queues the expected outputs from
//               an array-based model; a monitor pops and compares mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic        regwrite;
    logic        memtoreg;
    logic [31:0] read_data;
    logic [31:0] mem_alu_result;
    logic [4:0]  mem_write_reg;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic [31:0] commit_count;

    wb_regfile #(
        .DATA_W         (32),
        .ADDR_W         (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .regwrite       (regwrite),
        .memtoreg       (memtoreg),
        .read_data      (read_data),
        .mem_alu_result (mem_alu_result),
        .mem_write_reg  (mem_write_reg),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .wb_data        (wb_data),
        .wb_valid       (wb_valid),
        .commit_count   (commit_count)
    );

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] wb;
        logic        v;
        logic [31:0] cnt;
        string       tag;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl [32];
    logic [31:0] mcnt;
    int          checks;
    int          passed;
    bit          drv_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register read as seen by decode, from the architectural rules
    function automatic logic [31:0] model_read(input logic [4:0] a, input bit v,
                                               input logic [4:0] wr, input logic [31:0] wbd);
        if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (v && a == wr) return wbd;
`endif
        return mdl[a];
    endfunction

    // Apply one cycle of stimulus at the falling edge and queue its expectation
    task automatic cyc(input bit rst, input bit we, input bit m2r,
                       input logic [31:0] rd, input logic [31:0] alu,
                       input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                       input string tag);
        exp_t        e;
        logic [31:0] wbd;
        bit          v;
        rst_n          = rst;
        regwrite       = we;
        memtoreg       = m2r;
        read_data      = rd;
        mem_alu_result = alu;
        mem_write_reg  = wr;
        rs_addr        = rs;
        rt_addr        = rt;
        if (!rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
            mcnt = 32'd0;
        end
        wbd   = m2r ? rd : alu;
        v     = we && (wr != 5'd0);
        e.rs  = model_read(rs, v, wr, wbd);
        e.rt  = model_read(rt, v, wr, wbd);
        e.wb  = wbd;
        e.v   = v;
        e.cnt = mcnt;
        e.tag = tag;
        q.push_back(e);
        if (rst && v) begin
            mdl[wr] = wbd;
            mcnt    = mcnt + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic chk(input string name, input string tag,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s/%s: got %h expected %h", tag, name, act, req);
    endtask

    // Monitor: compares the DUT's combinational outputs mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rs_data", e.tag, rs_data, e.rs);
                chk("rt_data", e.tag, rt_data, e.rt);
                chk("wb_data", e.tag, wb_data, e.wb);
                chk("wb_valid", e.tag, {31'd0, wb_valid}, {31'd0, e.v});
                chk("commit_count", e.tag, commit_count, e.cnt);
            end
        end
    end

    // Driver: directed cases from the test plan, then randomized traffic
    initial begin
        logic [4:0] wr;
        logic [4:0] rs;
        logic [4:0] rt;
        checks   = 0;
        passed   = 0;
        drv_done = 1'b0;
        mcnt     = 32'd0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        rst_n = 1'b0; regwrite = 1'b0; memtoreg = 1'b0;
        read_data = '0; mem_alu_result = '0; mem_write_reg = '0;
        rs_addr = '0; rt_addr = '0;
        @(negedge clk);

        cyc(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd31, "reset");
        cyc(1, 1, 0, 32'h0, 32'h1234, 5'd5, 5'd5, 5'd5, "wr_r5");
        cyc(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5, "rd_r5");
        // Asynchronous reset: checked before any rising edge occurs
        cyc(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5, "async_rst");
        cyc(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5, "post_rst");

        cyc(1, 1, 1, 32'hDEADBEEF, 32'h1, 5'd8, 5'd8, 5'd0, "load_wr");
        cyc(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd8, "load_rd");

        cyc(1, 1, 0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, "r0_wr");
        cyc(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd8, "r0_rd");

        cyc(1, 1, 0, 32'h0, 32'h10, 5'd3, 5'd1, 5'd2, "r3_init");
        cyc(1, 1, 0, 32'h0, 32'h20, 5'd3, 5'd3, 5'd3, "r3_same");
        cyc(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3, "r3_after");

        cyc(1, 0, 0, 32'h0, 32'h55, 5'd7, 5'd7, 5'd7, "nowrite_r7");
        cyc(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd8, "nowrite_rd");

        // Counter wrap: preload the counter at the falling edge
        dut.r_commit_count = 32'hFFFF_FFFF;
        mcnt               = 32'hFFFF_FFFF;
        cyc(1, 1, 0, 32'h0, 32'h9, 5'd4, 5'd4, 5'd9, "wrap_wr");
        cyc(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0, "wrap_rd");

        for (int n = 0; n < 400; n++) begin
            wr = 5'($urandom_range(0, 31));
            rs = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            rt = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            cyc(($urandom_range(0, 49) != 0), $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, $urandom, $urandom, wr, rs, rt, "rand");
        end
        drv_done = 1'b1;
    end

    // Completion: drain the scoreboard within a bounded number of cycles
    initial begin
        wait (drv_done);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #3;
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_wb_regfile
`default_nettype wire
